// File: rtl/gfx_pkg.sv
// Shared constants for the TFT draw path.
//   - ILI9341 opcodes: CASET, PASET and RAMWR.
//   - Default panel limits: 320x240, landscape.
//   - Draw-engine state encoding.
//   - Mono colour constants.
//   - win_t and param_byte(), the helper that picks one CASET/PASET parameter byte.
package gfx_pkg;

  localparam logic [7:0] OP_CASET = 8'h2A;
  localparam logic [7:0] OP_PASET = 8'h2B;
  localparam logic [7:0] OP_RAMWR = 8'h2C;

  localparam int unsigned DEF_MAX_COL = 319;
  localparam int unsigned DEF_MAX_ROW = 239;

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;

  // Each state names the write that currently occupies (or last occupied) the bus.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CASET   = 3'd1;
  localparam logic [2:0] ST_CASET_P = 3'd2;
  localparam logic [2:0] ST_PASET   = 3'd3;
  localparam logic [2:0] ST_PASET_P = 3'd4;
  localparam logic [2:0] ST_RAMWR   = 3'd5;
  localparam logic [2:0] ST_PIXEL   = 3'd6;

  // Normalised, clipped window; coordinates are zero-extended to the panel's 16-bit format.
  typedef struct packed {
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
  } win_t;

  // Parameter order: start high, start low, end high, end low.
  function automatic logic [7:0] param_byte(input logic [15:0] s, input logic [15:0] e,
                                            input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = s[15:8];
      2'd1:    b = s[7:0];
      2'd2:    b = e[15:8];
      default: b = e[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tft_bus_slot.sv
// Single 8080-style write strobe generator. A slot lasts 2*WR_HALF clocks:
//   - wrx is low for the first WR_HALF clocks and high for the second WR_HALF.
//   - The panel samples on the rising edge of wrx.
// Ports:
//   clk, reset - clock and asynchronous active-high reset.
//   start      - request a new slot. Only asserted while idle or on the final clock of a slot,
//                which allows back-to-back slots.
//   pause_req  - while high, a requested slot is not started and wrx stays high.
//   wrx        - write strobe (active low).
//   slot_done  - high on the final clock of a slot.
module tft_bus_slot #(
  parameter int unsigned WR_HALF = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause_req,
  output logic wrx,
  output logic slot_done
);

  localparam int unsigned SLOT_LEN = 2 * WR_HALF;
  localparam int unsigned CNT_W    = $clog2(SLOT_LEN);

  if (WR_HALF < 1) begin : g_bad_wr_half
    $error("tft_bus_slot: WR_HALF must be at least 1");
  end

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic             w_go;
  logic             w_last;

  assign w_go      = start & ~pause_req;
  assign w_last    = r_run && (r_cnt == CNT_W'(SLOT_LEN - 1));
  assign slot_done = w_last;
  assign wrx       = ~(r_run && (r_cnt < CNT_W'(WR_HALF)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (w_go) begin
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (w_last) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tft_rect_writer.sv
// Rectangle-fill draw engine for an ILI9341 on an 8080-style write bus.
//
// Each accepted command produces this write sequence:
//   1. CASET + 4 parameter bytes.
//   2. PASET + 4 parameter bytes.
//   3. RAMWR.
//   4. One colour word per pixel.
// Coordinates are normalised (swapped when reversed) and clipped to MAX_COL/MAX_ROW.
//
// Optional build macro TFT_WINDOW_CACHE_EN: the last window sent is remembered, and a
// command with an identical window starts directly at RAMWR.
//
// Ports:
//   clk, reset            - clock and asynchronous active-high reset.
//   en                    - low pauses the engine at the next write boundary.
//   init_done             - gates command acceptance only.
//   cmd_valid / cmd_ready - command handshake.
//   x0, x1, y0, y1        - inclusive rectangle bounds.
//   color                 - fill colour; 1-bit mono or 16-bit RGB565.
//   busy                  - a transaction is in progress.
//   done                  - one-cycle pulse when a transaction ends.
//   tft_csx, tft_dcx, tft_wrx, tft_rdx, tft_data - panel bus.
module tft_rect_writer
  import gfx_pkg::*;
#(
  parameter int unsigned PIX_W   = 1,
  parameter int unsigned COL_W   = 9,
  parameter int unsigned ROW_W   = 8,
  parameter int unsigned MAX_COL = DEF_MAX_COL,
  parameter int unsigned MAX_ROW = DEF_MAX_ROW,
  parameter int unsigned WR_HALF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             init_done,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [COL_W-1:0] x0,
  input  logic [COL_W-1:0] x1,
  input  logic [ROW_W-1:0] y0,
  input  logic [ROW_W-1:0] y1,
  input  logic [PIX_W-1:0] color,
  output logic             busy,
  output logic             done,
  output logic             tft_csx,
  output logic             tft_dcx,
  output logic             tft_wrx,
  output logic             tft_rdx,
  output logic [15:0]      tft_data
);

  localparam int unsigned CNT_W = COL_W + ROW_W;

  if (PIX_W != 1 && PIX_W != 16) begin : g_bad_pix_w
    $error("tft_rect_writer: PIX_W must be 1 or 16");
  end

  // Command normalisation: clip each bound, then order the pair.
  logic [COL_W-1:0] w_xa, w_xb, w_xs, w_xe;
  logic [ROW_W-1:0] w_ya, w_yb, w_ys, w_ye;
  logic [CNT_W-1:0] w_ncols, w_nrows, w_npix;
  win_t             w_win;
  logic [15:0]      w_pix;

  assign w_xa = (x0 > COL_W'(MAX_COL)) ? COL_W'(MAX_COL) : x0;
  assign w_xb = (x1 > COL_W'(MAX_COL)) ? COL_W'(MAX_COL) : x1;
  assign w_ya = (y0 > ROW_W'(MAX_ROW)) ? ROW_W'(MAX_ROW) : y0;
  assign w_yb = (y1 > ROW_W'(MAX_ROW)) ? ROW_W'(MAX_ROW) : y1;
  assign w_xs = (w_xa > w_xb) ? w_xb : w_xa;
  assign w_xe = (w_xa > w_xb) ? w_xa : w_xb;
  assign w_ys = (w_ya > w_yb) ? w_yb : w_ya;
  assign w_ye = (w_ya > w_yb) ? w_ya : w_yb;
  assign w_win = {16'(w_xs), 16'(w_xe), 16'(w_ys), 16'(w_ye)};

  assign w_ncols = CNT_W'(w_xe) - CNT_W'(w_xs) + CNT_W'(1);
  assign w_nrows = CNT_W'(w_ye) - CNT_W'(w_ys) + CNT_W'(1);
  assign w_npix  = w_ncols * w_nrows;

  if (PIX_W == 1) begin : g_mono
    assign w_pix = color[0] ? WHITE : BLACK;
  end else begin : g_rgb
    assign w_pix = color[15:0];
  end

  logic             r_cmd_ready, r_busy, r_done, r_csx, r_dcx, r_paused;
  logic [15:0]      r_data;
  logic [2:0]       r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  win_t             r_win;
  logic [15:0]      r_pix;

  logic w_accept, w_hit, w_more, w_adv_req, w_start, w_pause, w_fire, w_end;
  logic w_slot_done, w_wrx;

  assign w_accept = cmd_valid & r_cmd_ready;

`ifdef TFT_WINDOW_CACHE_EN
  logic r_cache_vld;
  win_t r_cache;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cache_vld <= 1'b0;
      r_cache     <= '0;
    end else if (w_accept) begin
      r_cache_vld <= 1'b1;
      r_cache     <= w_win;
    end
  end

  assign w_hit = r_cache_vld && (r_cache == w_win);
`else
  assign w_hit = 1'b0;
`endif

  // Next write to issue after the one currently tracked by r_state/r_idx.
  logic [2:0]  w_nstate;
  logic [1:0]  w_nidx;
  logic [15:0] w_ndata;
  logic        w_ndcx;

  always_comb begin
    w_nstate = r_state;
    w_nidx   = 2'd0;
    w_more   = 1'b1;
    case (r_state)
      ST_CASET:   w_nstate = ST_CASET_P;
      ST_CASET_P: begin
        w_nstate = (r_idx == 2'd3) ? ST_PASET : ST_CASET_P;
        w_nidx   = r_idx + 2'd1;
      end
      ST_PASET:   w_nstate = ST_PASET_P;
      ST_PASET_P: begin
        w_nstate = (r_idx == 2'd3) ? ST_RAMWR : ST_PASET_P;
        w_nidx   = r_idx + 2'd1;
      end
      ST_RAMWR:   w_nstate = ST_PIXEL;
      ST_PIXEL:   w_more   = (r_cnt != '0);
      default:    w_more   = 1'b0;
    endcase

    w_ndcx  = 1'b1;
    w_ndata = 16'h0000;
    case (w_nstate)
      ST_CASET_P: w_ndata = {8'h00, param_byte(r_win.xs, r_win.xe, w_nidx)};
      ST_PASET_P: w_ndata = {8'h00, param_byte(r_win.ys, r_win.ye, w_nidx)};
      ST_PASET: begin
        w_ndata = {8'h00, OP_PASET};
        w_ndcx  = 1'b0;
      end
      ST_RAMWR: begin
        w_ndata = {8'h00, OP_RAMWR};
        w_ndcx  = 1'b0;
      end
      ST_PIXEL:   w_ndata = r_pix;
      default:    w_ndata = 16'h0000;
    endcase
  end

  // The first slot starts on the acceptance edge, so that slot is never held by en.
  assign w_adv_req = (w_slot_done | r_paused) & w_more;
  assign w_start   = w_accept | w_adv_req;
  assign w_pause   = ~en & ~w_accept;
  assign w_fire    = w_start & ~w_pause;
  assign w_end     = w_slot_done & (r_state == ST_PIXEL) & (r_cnt == '0);

  tft_bus_slot #(
    .WR_HALF (WR_HALF)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .pause_req (w_pause),
    .wrx       (w_wrx),
    .slot_done (w_slot_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_csx       <= 1'b1;
      r_dcx       <= 1'b1;
      r_data      <= 16'h0000;
      r_paused    <= 1'b0;
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_win       <= '0;
      r_pix       <= 16'h0000;
    end else begin
      r_done      <= 1'b0;
      r_cmd_ready <= en & init_done & (r_state == ST_IDLE) & ~w_accept;
      r_paused    <= w_adv_req & ~w_fire;
      if (w_accept) begin
        r_win   <= w_win;
        r_pix   <= w_pix;
        r_cnt   <= w_npix;
        r_idx   <= 2'd0;
        r_state <= w_hit ? ST_RAMWR : ST_CASET;
        r_data  <= {8'h00, (w_hit ? OP_RAMWR : OP_CASET)};
        r_dcx   <= 1'b0;
        r_csx   <= 1'b0;
        r_busy  <= 1'b1;
      end else if (w_fire) begin
        r_state <= w_nstate;
        r_idx   <= w_nidx;
        r_data  <= w_ndata;
        r_dcx   <= w_ndcx;
        if (w_nstate == ST_PIXEL) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end else if (w_end) begin
        r_state <= ST_IDLE;
        r_csx   <= 1'b1;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tft_csx   = r_csx;
  assign tft_dcx   = r_dcx;
  assign tft_wrx   = w_wrx;
  assign tft_rdx   = 1'b1;
  assign tft_data  = r_data;

endmodule

// File: doc/tft_rect_writer.md
Name: tft_rect_writer

Overview:
- Draw engine placed after the ILI9341 init sequencer; it owns the 8080-style TFT write bus once init_done is high.
- Accepts rectangle-fill commands on a valid/ready interface and emits the full write sequence per command: CASET window, PASET window, RAMWR opcode, then one colour word per pixel.
- Generalises single-pixel black/white writes to arbitrary rectangles, configurable colour depth and configurable bus strobe timing.

Parameters:
- PIX_W, 1, colour input width; legal values 1 (mono: 1 maps to 16'hFFFF, 0 maps to 16'h0000) or 16 (RGB565 pass-through); any other value is an elaboration error.
- COL_W, 9, column coordinate width.
- ROW_W, 8, row coordinate width.
- MAX_COL, 319, largest legal column; larger inputs are clipped to it.
- MAX_ROW, 239, largest legal row; larger inputs are clipped to it.
- WR_HALF, 1, clocks per wrx phase (low phase and high phase each); minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  enable; low pauses the engine at the next write boundary
- init_done  in  1  panel initialised; commands are refused while low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on a cycle where cmd_valid and cmd_ready are both high
- x0, x1  in  COL_W  column bounds (inclusive)
- y0, y1  in  ROW_W  row bounds (inclusive)
- color  in  PIX_W  fill colour
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse when a transaction ends
- tft_csx, tft_dcx, tft_wrx, tft_rdx  out  1  TFT bus controls (all active-low except dcx)
- tft_data  out  16  TFT data bus

Behaviour:
- Reset values: tft_csx=1, tft_dcx=1, tft_wrx=1, tft_rdx=1, tft_data=0, cmd_ready=0, busy=0, done=0. tft_rdx is held at 1 permanently.
- cmd_ready = en & init_done & (state==IDLE), registered.
- On acceptance, the block latches the command:
  - Normalises: if x0>x1 the two are swapped; same for y0/y1.
  - Clips each coordinate to MAX_COL / MAX_ROW.
  - Pixel count N=(x1-x0+1)*(y1-y0+1), held in a COL_W+ROW_W bit down-counter.
- States: IDLE -> CASET -> CASET_P (4 params) -> PASET -> PASET_P (4 params) -> RAMWR -> PIXEL (N writes) -> IDLE.
- Write timing (every write):
  - tft_data and tft_dcx are stable for the whole 2*WR_HALF-clock slot.
  - tft_wrx is low for the first WR_HALF clocks and high for the next WR_HALF; the panel samples on the wrx rising edge.
  - Opcodes (0x2A, 0x2B, 0x2C) are driven with dcx=0; params and pixels with dcx=1.
  - Bytes go on tft_data[7:0] with [15:8]=0.
  - Params are sent as start high byte, start low byte, end high byte, end low byte; coordinates are zero-extended to 16 bits.
- Latency: the cycle after acceptance has csx=0, dcx=0, data=0x002A and wrx=0. tft_csx stays low continuously until the end of the final slot.
- End of transaction: the cycle after the last slot, csx=1, done=1 for one cycle, busy=0 and state IDLE; cmd_ready is high the following cycle.
- Total transaction length is (11+N)*2*WR_HALF clocks.
- en low mid-transaction: the current slot completes, then the engine holds wrx=1, csx=0, data and dcx unchanged; it resumes with the next slot once en returns high. A pause never truncates a slot.
- init_done falling mid-transaction: ignored; it only gates acceptance.
- reset mid-transaction: immediate return to reset values and IDLE; the partially written window is abandoned.
- Pixel counter reaching 0 ends PIXEL; N=1 (single pixel) is legal.

Optional Feature:
- TFT_WINDOW_CACHE_EN: when defined, the block stores the last transmitted normalised window. A command with an identical window skips CASET/PASET and starts at RAMWR, with the first slot carrying data=0x002C; the transaction is then (1+N)*2*WR_HALF clocks.
- The cache is invalidated by reset.
- When undefined, every command sends the full 11-write header.

Decomposition:
- Package gfx_pkg holds:
  - ILI9341 opcode constants (CASET=8'h2A, PASET=8'h2B, RAMWR=8'h2C);
  - default MAX_COL/MAX_ROW;
  - the state encoding;
  - mono colour constants WHITE=16'hFFFF, BLACK=16'h0000.
- Sub-module tft_bus_slot: a WR_HALF-parametrised single-write strobe generator with inputs start and pause_req and outputs wrx and slot_done. The top block sequences header and pixels on top of it.

Test Plan:
- PIX_W=1, WR_HALF=1, command (5,0)-(5,0) color=1 -> 12 slots with data 2A,00,05,00,05,2B,00,00,00,00,2C,FFFF; dcx=0 only on the three opcodes; done pulses 24 clocks after the first csx low.
- Command (10,3)-(11,4) PIX_W=16 color=16'hF800 -> exactly 4 pixel writes of F800; CASET params 00,0A,00,0B.
- Swapped and oversize coordinates x0=400, x1=2, y0=7, y1=5 -> CASET 00,02,01,3F and PASET 00,05,00,07; N=318*3=954.
- en dropped during the 2nd pixel slot for 10 clocks -> the slot completes, wrx stays 1 and csx stays 0 for the pause, and the remaining pixels follow with no duplicates or skips.
- reset asserted during PASET_P -> on the same edge csx=1, wrx=1, busy=0; the next command starts with 0x2A.
- With TFT_WINDOW_CACHE_EN, the same window sent twice -> the second transaction starts with 0x2C and lasts (1+N)*2 clocks; with it undefined, the full header is sent again.
